// File: rtl/hazard_unit_if.sv
// Signal bundle between the RV32 pipeline (controller + datapath) and the hazard unit.
// The pipeline side drives indices, control and the memory handshake; the unit returns selects, stalls and flushes.
interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       RdE;
   logic [4:0]       RdM;
   logic [4:0]       RdW;
   logic [1:0]       ResultSrcE;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             PCSrcE;
   logic             MemReqM;
   logic             MemReadyM;

   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushW;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCycles;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemTimeout, StallCycles, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemTimeout, StallCycles, FlushCount
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage RV32 pipeline: forwarding, load-use and memory-wait stalls,
// redirect flushes, a wait-timeout monitor and saturating stall/flush counters.
module hazard_unit #(
   parameter int CNT_W   = 32,
   parameter int WAIT_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hif
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic mem_stall, lw_stall;
   logic stall_fd, stall_em, flush_d, flush_e, flush_w;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m, input logic [4:0] rd_m,
                                          input logic       wr_w, input logic [4:0] rd_w);
      if (wr_m && (rd_m != 5'd0) && (rs == rd_m)) return 2'b10;
      if (wr_w && (rd_w != 5'd0) && (rs == rd_w)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (&v) ? v : v + WAIT_W'(1);
   endfunction

   always_comb begin
      mem_stall = hif.MemReqM & ~hif.MemReadyM;
      lw_stall  = (hif.ResultSrcE == 2'b01) && (hif.RdE != 5'd0) &&
                  ((hif.Rs1D == hif.RdE) || (hif.Rs2D == hif.RdE));
   end

   // A pending memory access freezes the whole front of the pipe and holds any redirect in Execute.
   always_comb begin
      stall_fd = 1'b0;
      stall_em = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_w  = 1'b0;
      if (mem_stall) begin
         stall_fd = 1'b1;
         stall_em = 1'b1;
         flush_w  = 1'b1;
      end else begin
         stall_fd = lw_stall;
         flush_d  = hif.PCSrcE;
         flush_e  = lw_stall | hif.PCSrcE;
      end
   end

   assign hif.ForwardAE   = fwd_sel(hif.Rs1E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
   assign hif.ForwardBE   = fwd_sel(hif.Rs2E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
   assign hif.StallF      = stall_fd;
   assign hif.StallD      = stall_fd;
   assign hif.StallE      = stall_em;
   assign hif.StallM      = stall_em;
   assign hif.FlushD      = flush_d;
   assign hif.FlushE      = flush_e;
   assign hif.FlushW      = flush_w;
   assign hif.MemTimeout  = timeout_q;
   assign hif.StallCycles = stall_cnt_q;
   assign hif.FlushCount  = flush_cnt_q;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (mem_stall) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_stall) wait_d = sat_inc_wait(wait_q);
            if (hif.MemReadyM || !hif.MemReqM) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Sticky: the access is never aborted, the flag only reports that it ran long.
      if (mem_stall && (wait_q == TIMEOUT_C)) timeout_d = 1'b1;
      stall_cnt_d = stall_fd ? sat_inc_cnt(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush_d  ? sat_inc_cnt(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with small counters (CNT_W=3) and a short timeout (TIMEOUT=4).
module tb_hazard_unit;
   localparam int CNT_W   = 3;
   localparam int WAIT_W  = 3;
   localparam int TIMEOUT = 4;

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LW   = 7'b1100010;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_LWBR = 7'b1100110;
   localparam logic [6:0] C_MEM  = 7'b1111001;

   typedef struct {
      string      tag;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [6:0] ctl;
      logic       to;
      logic [2:0] sc;
      logic [2:0] fc;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t sb[$];

   hazard_unit_if #(.CNT_W(CNT_W)) hif ();

   hazard_unit #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr();
      hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
      hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.ResultSrcE = 2'b00;
      hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.PCSrcE = 1'b0;
      hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [6:0] ctl, input logic to, input int sc, input int fc);
      exp_t e;
      e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.to = to;
      e.sc = 3'(sc); e.fc = 3'(fc);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      cmp({e.tag, ".fwdA"}, 32'(hif.ForwardAE), 32'(e.fa));
      cmp({e.tag, ".fwdB"}, 32'(hif.ForwardBE), 32'(e.fb));
      cmp({e.tag, ".ctl"}, 32'({hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                                hif.FlushD, hif.FlushE, hif.FlushW}), 32'(e.ctl));
      cmp({e.tag, ".timeout"}, 32'(hif.MemTimeout), 32'(e.to));
      cmp({e.tag, ".stallcnt"}, 32'(hif.StallCycles), 32'(e.sc));
      cmp({e.tag, ".flushcnt"}, 32'(hif.FlushCount), 32'(e.fc));
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #2;
      chk("reset", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
      reset = 1'b1;
      cyc();

      // forwarding
      hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
      hif.Rs1E = 5'd5; hif.Rs2E = 5'd0;
      chk("fwd_m_prio", 2'b10, 2'b00, C_NONE, 1'b0, 0, 0);
      cyc();
      hif.RdM = 5'd0; hif.Rs2E = 5'd5;
      chk("fwd_w", 2'b01, 2'b01, C_NONE, 1'b0, 0, 0);
      cyc();
      hif.RegWriteW = 1'b0; hif.RdM = 5'd6; hif.Rs2E = 5'd6;
      chk("fwd_b_m", 2'b00, 2'b10, C_NONE, 1'b0, 0, 0);
      cyc();
      hif.RegWriteW = 1'b1; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
      chk("fwd_x0", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
      cyc();

      // load-use
      clr();
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
      chk("lw_use", 2'b00, 2'b00, C_LW, 1'b0, 0, 0);
      cyc();
      clr();
      chk("lw_done", 2'b00, 2'b00, C_NONE, 1'b0, 1, 0);
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd0;
      chk("lw_x0", 2'b00, 2'b00, C_NONE, 1'b0, 1, 0);
      cyc();

      // redirects, held during a memory wait
      clr();
      hif.PCSrcE = 1'b1;
      chk("br", 2'b00, 2'b00, C_BR, 1'b0, 1, 0);
      cyc();
      clr();
      chk("br_cnt", 2'b00, 2'b00, C_NONE, 1'b0, 1, 1);
      hif.PCSrcE = 1'b1; hif.MemReqM = 1'b1;
      chk("br_mem0", 2'b00, 2'b00, C_MEM, 1'b0, 1, 1);
      cyc();
      chk("br_mem1", 2'b00, 2'b00, C_MEM, 1'b0, 2, 1);
      cyc();
      hif.MemReadyM = 1'b1;
      chk("br_retry", 2'b00, 2'b00, C_BR, 1'b0, 3, 1);
      cyc();
      clr();
      chk("br_retry_cnt", 2'b00, 2'b00, C_NONE, 1'b0, 3, 2);
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1;
      chk("lw_br", 2'b00, 2'b00, C_LWBR, 1'b0, 3, 2);
      cyc();
      clr();
      chk("lw_br_cnt", 2'b00, 2'b00, C_NONE, 1'b0, 4, 3);

      // three-cycle wait with a load-use hazard that must be ignored
      pulse_reset();
      cyc();
      clr();
      hif.MemReqM = 1'b1; hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wait3_%0d", k), 2'b00, 2'b00, C_MEM, 1'b0, k, 0);
         cyc();
      end
      clr();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
      chk("wait3_rdy", 2'b00, 2'b00, C_NONE, 1'b0, 3, 0);
      cyc();

      // five stall cycles: no timeout once the wait counter restarts from zero
      clr();
      hif.MemReqM = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("wait5_%0d", k), 2'b00, 2'b00, C_MEM, 1'b0, (3 + k > 7) ? 7 : 3 + k, 0);
         cyc();
      end
      hif.MemReadyM = 1'b1;
      chk("wait5_rdy", 2'b00, 2'b00, C_NONE, 1'b0, 7, 0);
      cyc();
      clr();
      chk("wait5_sat", 2'b00, 2'b00, C_NONE, 1'b0, 7, 0);

      // timeout after the fifth wait cycle, sticky afterwards
      pulse_reset();
      cyc();
      clr();
      hif.MemReqM = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("to_%0d", k), 2'b00, 2'b00, C_MEM, (k >= 6), (k > 7) ? 7 : k, 0);
         cyc();
      end
      hif.MemReadyM = 1'b1;
      chk("to_rdy", 2'b00, 2'b00, C_NONE, 1'b1, 7, 0);
      cyc();
      clr();
      chk("to_sticky", 2'b00, 2'b00, C_NONE, 1'b1, 7, 0);
      cyc();

      // asynchronous reset in the middle of a wait
      hif.MemReqM = 1'b1;
      chk("pre_rst", 2'b00, 2'b00, C_MEM, 1'b1, 7, 0);
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_mid", 2'b00, 2'b00, C_MEM, 1'b0, 0, 0);
      reset = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk($sformatf("post_rst_%0d", k), 2'b00, 2'b00, C_MEM, (k >= 6), k, 0);
      end
      clr();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard unit for the five-stage RV32 core.
- Consumes the per-stage control signals produced by the pipelined controller: RegWriteM/W, ResultSrcE, PCSrcE.
- Also consumes register indices from the datapath and a data-memory ready handshake.
- Returns forwarding selects, stall enables and flushes (including FlushE back to the controller), plus a memory-wait FSM with timeout detection and saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- WAIT_W, 8, width of the memory-wait cycle counter.
- TIMEOUT, 255, number of consecutive wait cycles (up to 2^WAIT_W-1) after which MemTimeout is raised.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Rs1D  input  5  source register 1 of the instruction in Decode.
- Rs2D  input  5  source register 2 of the instruction in Decode.
- Rs1E  input  5  source register 1 of the instruction in Execute.
- Rs2E  input  5  source register 2 of the instruction in Execute.
- RdE  input  5  destination register in Execute.
- RdM  input  5  destination register in Memory.
- RdW  input  5  destination register in Writeback.
- ResultSrcE  input  2  result select in Execute; 2'b01 means load.
- RegWriteM  input  1  register write enable in Memory.
- RegWriteW  input  1  register write enable in Writeback.
- PCSrcE  input  1  branch taken or jump in Execute.
- MemReqM  input  1  load or store active in Memory.
- MemReadyM  input  1  data memory completes the access this cycle.
- ForwardAE  output  2  ALU operand A select: 00 register file, 10 ALUResultM, 01 ResultW.
- ForwardBE  output  2  ALU operand B select, same encoding.
- StallF  output  1  hold PC register.
- StallD  output  1  hold IF/ID register.
- StallE  output  1  hold ID/EX register.
- StallM  output  1  hold EX/MEM register.
- FlushD  output  1  clear IF/ID register.
- FlushE  output  1  clear ID/EX register.
- FlushW  output  1  clear MEM/WB register (inject bubble).
- MemTimeout  output  1  sticky: a wait exceeded TIMEOUT.
- StallCycles  output  CNT_W  count of cycles with StallF asserted.
- FlushCount  output  CNT_W  count of accepted redirects.

Behaviour:
- Forwarding (combinational), shown for A; B is identical using Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && Rs1E==RdM.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && Rs1E==RdW.
  - Otherwise ForwardAE=00.
  - Memory stage has priority over Writeback.
- memStall = MemReqM & ~MemReadyM (combinational; no added latency).
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- While memStall=1:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0: a taken branch is held in Execute and its redirect retries once memStall drops.
  - lwStall is ignored.
- While memStall=0:
  - StallF=StallD=lwStall; StallE=StallM=FlushW=0.
  - FlushD=PCSrcE; FlushE=lwStall|PCSrcE.
  - lwStall and PCSrcE together: both apply (flush wins for D).
- FSM states IDLE, WAIT; encoding is free.
  - IDLE->WAIT when memStall.
  - WAIT->IDLE when MemReadyM or ~MemReqM.
  - WAIT->WAIT otherwise.
- Wait counter:
  - Cleared in IDLE.
  - Increments each WAIT cycle in which memStall holds, saturating at all ones.
  - When the counter equals TIMEOUT while memStall=1, MemTimeout is set on the next edge.
  - MemTimeout stays set until reset; stalls continue (the unit never aborts an access).
- Counters:
  - StallCycles increments on every clk with StallF=1.
  - FlushCount increments on every clk with FlushD=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
- Reset (async, reset=0), including mid-WAIT:
  - state=IDLE; wait counter, MemTimeout, StallCycles and FlushCount all 0.
  - Combinational outputs follow inputs; register write-back is inhibited only by the datapath registers' own reset.
- Register x0 never forwards and never causes lwStall.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; RdM=0 -> ForwardAE=01.
- Load in E (ResultSrcE=01, RdE=7), Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle, StallCycles increments by 1; RdE=0 -> no stall.
- PCSrcE=1, memStall=0 -> FlushD=FlushE=1, FlushCount+1; same with MemReqM=1, MemReadyM=0 -> no flush and all four stalls + FlushW=1 until MemReadyM=1, then the flush is taken.
- MemReqM=1, MemReadyM low 3 cycles -> FSM in WAIT 3 cycles, StallCycles=3, MemTimeout=0, back to IDLE after ready.
- TIMEOUT=4, MemReadyM held low 10 cycles -> MemTimeout rises after the 5th wait cycle and stays 1 after ready returns.
- reset pulsed low mid-WAIT with counters nonzero -> immediately state IDLE, counters 0, MemTimeout 0; StallCycles saturation checked with CNT_W=3 (stays 7).
